// File: rtl/ahb_apb_pkg.sv
// rtl/ahb_apb_pkg.sv - shared AHB/APB encodings and bridge state type
// Purpose: constants for AHB transfer/burst/response fields, the bridge
//          state encoding, and a helper deriving hsize from the data width.
// Ports:   none (package).
package ahb_apb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;

  localparam logic       HRESP_OKAY    = 1'b0;
  localparam logic       HRESP_ERROR   = 1'b1;

  typedef enum logic [1:0] {
    BR_IDLE = 2'd0,
    BR_ADDR = 2'd1,
    BR_DATA = 2'd2,
    BR_RESP = 2'd3
  } br_state_t;

  // hsize encodes log2 of bytes per beat; every transfer is full bus width.
  function automatic logic [2:0] hsize_for(input int data_width);
    return 3'($clog2(data_width / 8));
  endfunction

endpackage

// File: rtl/apb_ahb_bridge_if.sv
// rtl/apb_ahb_bridge_if.sv - APB completer + AHB-Lite initiator signal bundle
// Purpose: groups the APB-side and AHB-side bus signals of the bridge.
// Modports:
//   slave  - the bridge: APB completer inputs/outputs and AHB initiator outputs.
//   master - the environment: APB requester and AHB memory/responder.
// Signals: psel, penable, paddr, pwrite, pwdata, prdata, pready, pslverr,
//          haddr, htrans, hwrite, hsize, hburst, hwdata, hrdata, hready, hresp.
interface apb_ahb_bridge_if #(
  parameter int HADDR_WIDTH = 32,
  parameter int PADDR_WIDTH = 30,
  parameter int DATA_WIDTH  = 64
);

  logic                   psel;
  logic                   penable;
  logic [PADDR_WIDTH-1:0] paddr;
  logic                   pwrite;
  logic [DATA_WIDTH-1:0]  pwdata;
  logic [DATA_WIDTH-1:0]  prdata;
  logic                   pready;
  logic                   pslverr;

  logic [HADDR_WIDTH-1:0] haddr;
  logic [1:0]             htrans;
  logic                   hwrite;
  logic [2:0]             hsize;
  logic [2:0]             hburst;
  logic [DATA_WIDTH-1:0]  hwdata;
  logic [DATA_WIDTH-1:0]  hrdata;
  logic                   hready;
  logic                   hresp;

  modport slave (
    input  psel, penable, paddr, pwrite, pwdata,
    output prdata, pready, pslverr,
    output haddr, htrans, hwrite, hsize, hburst, hwdata,
    input  hrdata, hready, hresp
  );

  modport master (
    output psel, penable, paddr, pwrite, pwdata,
    input  prdata, pready, pslverr,
    input  haddr, htrans, hwrite, hsize, hburst, hwdata,
    output hrdata, hready, hresp
  );

endinterface

// File: rtl/ahb_mst_if.sv
// rtl/ahb_mst_if.sv - single-transfer AHB-Lite initiator (address/data phases)
// Purpose: turns one request pulse into one NONSEQ transfer and reports
//          completion with the sampled read data and response.
// Ports:
//   hclk, hresetn           clock, asynchronous active-low reset
//   s_addr                  full AHB address, sampled with the request pulse
//   s_wrreq, s_rdreq        one-cycle request pulses (mutually exclusive)
//   s_wdata                 write data, sampled when the address phase ends
//   s_rdata, s_ack, s_error completion strobe with read data and error flag
//   htrans, haddr, hwrite,
//   hwdata                  registered AHB initiator outputs
//   hrdata, hready, hresp   AHB responder inputs
module ahb_mst_if
  import ahb_apb_pkg::*;
#(
  parameter int HADDR_WIDTH = 32,
  parameter int DATA_WIDTH  = 64
) (
  input  logic                   hclk,
  input  logic                   hresetn,
  input  logic [HADDR_WIDTH-1:0] s_addr,
  input  logic                   s_wrreq,
  input  logic                   s_rdreq,
  input  logic [DATA_WIDTH-1:0]  s_wdata,
  output logic [DATA_WIDTH-1:0]  s_rdata,
  output logic                   s_ack,
  output logic                   s_error,
  output logic [1:0]             htrans,
  output logic [HADDR_WIDTH-1:0] haddr,
  output logic                   hwrite,
  output logic [DATA_WIDTH-1:0]  hwdata,
  input  logic [DATA_WIDTH-1:0]  hrdata,
  input  logic                   hready,
  input  logic                   hresp
);

  br_state_t state;

  // Completion is flagged only when the data phase actually ends, so the
  // first (hready low) cycle of a two-cycle ERROR response is never seen.
  assign s_ack   = (state == BR_DATA) && hready;
  assign s_error = s_ack && (hresp == HRESP_ERROR);
  assign s_rdata = hrdata;

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state  <= BR_IDLE;
      htrans <= HTRANS_IDLE;
      haddr  <= '0;
      hwrite <= 1'b0;
      hwdata <= '0;
    end else begin
      case (state)
        BR_IDLE: begin
          if (s_wrreq || s_rdreq) begin
            htrans <= HTRANS_NONSEQ;
            haddr  <= s_addr;
            hwrite <= s_wrreq;
            state  <= BR_ADDR;
          end
        end
        BR_ADDR: begin
          // Address-phase signals are held untouched while hready is low.
          if (hready) begin
            htrans <= HTRANS_IDLE;
            hwdata <= s_wdata;
            state  <= BR_DATA;
          end
        end
        BR_DATA: begin
          if (hready) begin
            state <= BR_IDLE;
          end
        end
        default: begin
          htrans <= HTRANS_IDLE;
          state  <= BR_IDLE;
        end
      endcase
    end
  end

endmodule

// File: rtl/apb_ahb_bridge.sv
// rtl/apb_ahb_bridge.sv - APB completer to AHB-Lite initiator bridge
// Purpose: each APB transfer becomes exactly one full-width AHB SINGLE/NONSEQ
//          transfer; pready is held low until the AHB data phase completes.
//          Misaligned APB addresses are rejected without touching the AHB bus.
// Ports:
//   hclk     shared APB/AHB clock
//   hresetn  asynchronous active-low reset
//   bus      apb_ahb_bridge_if.slave: APB completer side (psel, penable,
//            paddr, pwrite, pwdata, prdata, pready, pslverr) and AHB
//            initiator side (haddr, htrans, hwrite, hsize, hburst, hwdata,
//            hrdata, hready, hresp)
module apb_ahb_bridge
  import ahb_apb_pkg::*;
#(
  parameter int HADDR_WIDTH = 32,
  parameter int PADDR_WIDTH = 30,
  parameter int DATA_WIDTH  = 64,
  parameter logic [HADDR_WIDTH-PADDR_WIDTH-1:0] HADDR_PREFIX = '0,
  parameter int STRB_WIDTH  = DATA_WIDTH / 8
) (
  input logic             hclk,
  input logic             hresetn,
  apb_ahb_bridge_if.slave bus
);

  // Low address bits that must be zero for a full-width beat.
  localparam logic [PADDR_WIDTH-1:0] ALIGN_MASK = PADDR_WIDTH'(STRB_WIDTH - 1);

  br_state_t             state;
  logic                  cap_write;
  logic [DATA_WIDTH-1:0] cap_wdata;

  logic                   setup;
  logic                   misaligned;
  logic                   start;
  logic [HADDR_WIDTH-1:0] s_addr;
  logic                   s_wrreq;
  logic                   s_rdreq;
  logic [DATA_WIDTH-1:0]  s_rdata;
  logic                   s_ack;
  logic                   s_error;

  // psel is only looked at in IDLE; a requester dropping it mid-transfer
  // cannot cut short the AHB transfer or the response pulse.
  assign setup      = (state == BR_IDLE) && bus.psel && !bus.penable;
  assign misaligned = (bus.paddr & ALIGN_MASK) != '0;
  assign start      = setup && !misaligned;

  // The initiator registers the address in the setup cycle so that NONSEQ
  // appears in the very next cycle.
  assign s_addr  = {HADDR_PREFIX, bus.paddr};
  assign s_wrreq = start && bus.pwrite;
  assign s_rdreq = start && !bus.pwrite;

  assign bus.hsize  = hsize_for(DATA_WIDTH);
  assign bus.hburst = HBURST_SINGLE;

  ahb_mst_if #(
    .HADDR_WIDTH (HADDR_WIDTH),
    .DATA_WIDTH  (DATA_WIDTH)
  ) u_ahb_mst (
    .hclk    (hclk),
    .hresetn (hresetn),
    .s_addr  (s_addr),
    .s_wrreq (s_wrreq),
    .s_rdreq (s_rdreq),
    .s_wdata (cap_wdata),
    .s_rdata (s_rdata),
    .s_ack   (s_ack),
    .s_error (s_error),
    .htrans  (bus.htrans),
    .haddr   (bus.haddr),
    .hwrite  (bus.hwrite),
    .hwdata  (bus.hwdata),
    .hrdata  (bus.hrdata),
    .hready  (bus.hready),
    .hresp   (bus.hresp)
  );

  // pready/pslverr are registers set on entry to RESP and cleared on the
  // following edge, giving a one-cycle pulse with no path from APB inputs.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state      <= BR_IDLE;
      cap_write  <= 1'b0;
      cap_wdata  <= '0;
      bus.prdata <= '0;
      bus.pready <= 1'b0;
      bus.pslverr <= 1'b0;
    end else begin
      bus.pready  <= 1'b0;
      bus.pslverr <= 1'b0;
      case (state)
        BR_IDLE: begin
          if (setup) begin
            cap_write <= bus.pwrite;
            cap_wdata <= bus.pwdata;
            if (misaligned) begin
              bus.pready  <= 1'b1;
              bus.pslverr <= 1'b1;
              state       <= BR_RESP;
            end else begin
              state <= BR_ADDR;
            end
          end
        end
        BR_ADDR: begin
          if (bus.hready) begin
            state <= BR_DATA;
          end
        end
        BR_DATA: begin
          if (s_ack) begin
            bus.pready  <= 1'b1;
            bus.pslverr <= s_error;
            // Reads load prdata even on ERROR; writes leave it untouched.
            if (!cap_write) begin
              bus.prdata <= s_rdata;
            end
            state <= BR_RESP;
          end
        end
        BR_RESP: begin
          state <= BR_IDLE;
        end
        default: begin
          state <= BR_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb_ahb_bridge.sv
// tb/tb_apb_ahb_bridge.sv - self-checking bench for apb_ahb_bridge
module tb_apb_ahb_bridge;
  import ahb_apb_pkg::*;

  logic hclk = 1'b0;
  logic hresetn;
  always #5 hclk = ~hclk;

  apb_ahb_bridge_if #(.HADDR_WIDTH(32), .PADDR_WIDTH(30), .DATA_WIDTH(64)) bus ();

  apb_ahb_bridge #(
    .HADDR_WIDTH  (32),
    .PADDR_WIDTH  (30),
    .DATA_WIDTH   (64),
    .HADDR_PREFIX (2'b00)
  ) dut (
    .hclk    (hclk),
    .hresetn (hresetn),
    .bus     (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int n_nonseq;

  // ref_mem: what the APB side should see; slv_mem: the AHB memory contents.
  logic [63:0] ref_mem [logic [31:0]];
  logic [63:0] slv_mem [logic [31:0]];
  logic [63:0] exp_prdata;

  function automatic logic [63:0] dflt(input logic [31:0] a);
    return {a ^ 32'hA5A5_0000, ~a};
  endfunction

  function automatic logic [63:0] ref_read(input logic [29:0] a);
    logic [31:0] ha;
    ha = {2'b00, a};
    return ref_mem.exists(ha) ? ref_mem[ha] : dflt(ha);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One APB transfer with the bench acting as AHB memory.
  // aw/dw: hready-low cycles in address/data phase; err: ERROR response.
  task automatic xfer(input logic [29:0] addr, input logic wr, input logic [63:0] wd,
                      input int aw, input int dw, input logic err, input logic drop_psel);
    logic        mis;
    logic        done;
    logic [1:0]  prev_htrans;
    logic [31:0] slv_addr;
    int          exp_lat;
    int          a_left;
    int          d_left;
    int          phase;
    mis      = (addr[2:0] != 3'b000);
    exp_lat  = mis ? 1 : 3 + aw + dw;
    a_left   = aw;
    d_left   = (err && dw == 0) ? 1 : dw;
    if (err && dw == 0) exp_lat = exp_lat + 1;
    phase    = 0;
    done     = 1'b0;
    slv_addr = '0;
    n_nonseq = 0;
    prev_htrans = bus.htrans;
    bus.psel = 1'b1; bus.penable = 1'b0; bus.paddr = addr;
    bus.pwrite = wr; bus.pwdata = wd; bus.hready = 1'b1; bus.hresp = 1'b0;
    @(posedge hclk);
    for (int k = 1; k <= 40 && !done; k++) begin
      @(negedge hclk);
      if (k == 1) bus.penable = 1'b1;
      if (k == 2 && drop_psel) begin bus.psel = 1'b0; bus.penable = 1'b0; end
      if (bus.htrans === HTRANS_NONSEQ && prev_htrans !== HTRANS_NONSEQ) begin
        n_nonseq++;
        chk("nonseq_cycle", k, 1);
      end
      prev_htrans = bus.htrans;
      if (bus.pready === 1'b1) begin
        done = 1'b1;
        chk("latency", k, exp_lat);
        chk("pslverr", bus.pslverr, mis | err);
        if (!wr && !mis) exp_prdata = ref_read(addr);
        chk("prdata", bus.prdata, exp_prdata);
      end else begin
        chk("pslverr_low", bus.pslverr, 1'b0);
        case (phase)
          0: if (bus.htrans === HTRANS_NONSEQ) begin
               chk("haddr", bus.haddr, {2'b00, addr});
               chk("hwrite", bus.hwrite, wr);
               slv_addr = bus.haddr;
               if (a_left > 0) begin bus.hready = 1'b0; a_left--; end
               else begin bus.hready = 1'b1; phase = 1; end
             end
          1: begin
               chk("htrans_data", bus.htrans, HTRANS_IDLE);
               if (wr) chk("hwdata", bus.hwdata, wd);
               if (d_left > 0) begin
                 bus.hready = 1'b0;
                 bus.hresp  = err && (d_left == 1);
                 bus.hrdata = {$urandom, $urandom};
                 d_left--;
               end else begin
                 bus.hready = 1'b1;
                 bus.hresp  = err;
                 if (wr) begin
                   if (!err) slv_mem[slv_addr] = bus.hwdata;
                 end else begin
                   bus.hrdata = slv_mem.exists(slv_addr) ? slv_mem[slv_addr] : dflt(slv_addr);
                 end
                 phase = 2;
               end
             end
          default: ;
        endcase
      end
    end
    chk("pready_seen", done, 1'b1);
    chk("nonseq_count", n_nonseq, mis ? 0 : 1);
    if (wr && !mis && !err) ref_mem[{2'b00, addr}] = wd;
    @(posedge hclk);
    #1;
    bus.psel = 1'b0; bus.penable = 1'b0; bus.hready = 1'b1; bus.hresp = 1'b0;
  endtask

  initial begin
    logic [29:0] ra;
    logic        rw;
    logic [63:0] rd;
    int          raw;
    int          rdw;
    logic        rerr;

    hresetn = 1'b0;
    bus.psel = 1'b0; bus.penable = 1'b0; bus.paddr = '0; bus.pwrite = 1'b0;
    bus.pwdata = '0; bus.hrdata = '0; bus.hready = 1'b1; bus.hresp = 1'b0;
    exp_prdata = '0;
    repeat (3) @(posedge hclk);
    @(negedge hclk);
    chk("rst_htrans", bus.htrans, HTRANS_IDLE);
    chk("rst_haddr", bus.haddr, 32'h0);
    chk("rst_hwrite", bus.hwrite, 1'b0);
    chk("rst_hwdata", bus.hwdata, 64'h0);
    chk("rst_prdata", bus.prdata, 64'h0);
    chk("rst_pready", bus.pready, 1'b0);
    chk("rst_pslverr", bus.pslverr, 1'b0);
    chk("hsize", bus.hsize, 3'd3);
    chk("hburst", bus.hburst, 3'b000);
    hresetn = 1'b1;

    slv_mem[32'h100] = 64'hDEAD_BEEF_0123_4567;
    ref_mem[32'h100] = 64'hDEAD_BEEF_0123_4567;
    xfer(30'h100, 1'b0, 64'h0, 0, 0, 1'b0, 1'b0);
    xfer(30'h208, 1'b1, 64'h1122_3344_5566_7788, 0, 0, 1'b0, 1'b0);
    xfer(30'h208, 1'b0, 64'h0, 1, 0, 1'b0, 1'b0);
    xfer(30'h10, 1'b0, 64'h0, 0, 3, 1'b0, 1'b0);
    xfer(30'h40, 1'b1, 64'h5555_AAAA_0F0F_F0F0, 0, 1, 1'b1, 1'b0);
    xfer(30'h104, 1'b0, 64'h0, 0, 0, 1'b0, 1'b0);
    xfer(30'h40, 1'b0, 64'h0, 0, 0, 1'b0, 1'b0);
    xfer(30'h18, 1'b1, 64'h0BAD_C0DE_1234_5678, 0, 0, 1'b0, 1'b1);
    xfer(30'h18, 1'b0, 64'h0, 2, 2, 1'b0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      ra = 30'($urandom_range(0, 31)) << 3;
      if ($urandom_range(0, 3) == 0) ra[2:0] = 3'($urandom_range(1, 7));
      rw   = 1'($urandom_range(0, 1));
      rd   = {$urandom, $urandom};
      raw  = $urandom_range(0, 3);
      rdw  = $urandom_range(0, 3);
      rerr = ($urandom_range(0, 4) == 0);
      xfer(ra, rw, rd, raw, rdw, rerr, 1'b0);
    end

    // Reset while a write sits in its data phase.
    bus.psel = 1'b1; bus.penable = 1'b0; bus.paddr = 30'h300; bus.pwrite = 1'b1;
    bus.pwdata = 64'hCAFE_F00D_8BAD_F00D;
    @(posedge hclk);
    @(negedge hclk);
    bus.penable = 1'b1;
    chk("rst_pre_nonseq", bus.htrans, HTRANS_NONSEQ);
    bus.hready = 1'b1;
    @(posedge hclk);
    @(negedge hclk);
    bus.hready = 1'b0;
    chk("rst_pre_hwdata", bus.hwdata, 64'hCAFE_F00D_8BAD_F00D);
    hresetn = 1'b0;
    #1;
    chk("arst_htrans", bus.htrans, HTRANS_IDLE);
    chk("arst_haddr", bus.haddr, 32'h0);
    chk("arst_hwrite", bus.hwrite, 1'b0);
    chk("arst_hwdata", bus.hwdata, 64'h0);
    chk("arst_prdata", bus.prdata, 64'h0);
    chk("arst_pready", bus.pready, 1'b0);
    chk("arst_pslverr", bus.pslverr, 1'b0);
    bus.psel = 1'b0; bus.penable = 1'b0;
    exp_prdata = '0;
    repeat (2) @(posedge hclk);
    @(negedge hclk);
    hresetn = 1'b1;
    bus.hready = 1'b1;
    xfer(30'h0, 1'b0, 64'h0, 0, 0, 1'b0, 1'b0);
    xfer(30'h300, 1'b0, 64'h0, 0, 0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
